// File: rtl/string_hw_avalon_if.sv
// Avalon-MM slave bus bundle for the GCD accelerator.
// The master drives the strobes and address; the slave returns combinational read data.
interface string_hw_avalon_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (output chipselect, address, write, writedata, read, input readdata);
    modport slave  (input chipselect, address, write, writedata, read, output readdata);
endinterface

// File: rtl/string_hw_avalon.sv
// Memory-mapped binary (Stein) GCD accelerator: A, B, CONTROL and RESULT registers.
// Each reduction step runs in one clock using a single-cycle count-trailing-zeros encoder.
//
// state | meaning
// IDLE  | waiting for go; A/B writable, done holds the last completion
// ITER  | one Stein reduction per clock until the odd working values meet
module string_hw_avalon (
    input  logic               clk,
    input  logic               resetn,
    string_hw_avalon_if.slave  bus
);
    typedef enum logic {IDLE, ITER} state_t;

    state_t      state;
    logic [31:0] reg_a, reg_b, result;
    logic [31:0] wa, wb;
    logic [4:0]  k;
    logic        done, busy;

    logic        wr_en;
    logic [31:0] mn, mx, diff, diff_odd;
    logic [31:0] a_odd, b_odd;
    logic [4:0]  k_go;

    function automatic logic [4:0] ctz32(input logic [31:0] v);
        ctz32 = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) ctz32 = 5'(i);
        end
    endfunction

    assign wr_en = bus.chipselect & bus.write;

    always_comb begin
        mn       = (wa < wb) ? wa : wb;
        mx       = (wa < wb) ? wb : wa;
        diff     = mx - mn;
        diff_odd = diff >> ctz32(diff);
        a_odd    = reg_a >> ctz32(reg_a);
        b_odd    = reg_b >> ctz32(reg_b);
        k_go     = ctz32(reg_a | reg_b);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            reg_a  <= '0;
            reg_b  <= '0;
            result <= '0;
            wa     <= '0;
            wb     <= '0;
            k      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        case (bus.address)
                            3'd0: reg_a <= bus.writedata;
                            3'd1: reg_b <= bus.writedata;
                            3'd2: begin
                                if (bus.writedata[0]) begin
                                    // Zero operand short-circuits: gcd(x,0)=x, gcd(0,0)=0
                                    if (reg_a == '0 || reg_b == '0) begin
                                        result <= reg_a | reg_b;
                                        done   <= 1'b1;
                                    end else begin
                                        wa    <= a_odd;
                                        wb    <= b_odd;
                                        k     <= k_go;
                                        busy  <= 1'b1;
                                        done  <= 1'b0;
                                        state <= ITER;
                                    end
                                end else if (bus.writedata[1]) begin
                                    done <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ITER: begin
                    if (wa == wb) begin
                        result <= wa << k;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        wa <= mn;
                        wb <= diff_odd;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect && bus.read) begin
            case (bus.address)
                3'd0: bus.readdata = reg_a;
                3'd1: bus.readdata = reg_b;
                3'd2: bus.readdata = {28'd0, busy, done, 2'b00};
                3'd3: bus.readdata = result;
                default: bus.readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_string_hw_avalon.sv
// Self-checking bench for the GCD accelerator: directed vector table, busy/reset
// corner sequences, and random operands against a Euclid reference model.
module tb_string_hw_avalon;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    string_hw_avalon_if bus ();

    string_hw_avalon dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          max_lat;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = addr;
        bus.writedata  = data;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = addr;
        #1;
        data           = bus.readdata;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        #1;
    endtask

    // Polls done after the go edge; cycles = clock edges after the go edge.
    task automatic wait_done(input int limit, output int cycles, output logic ok);
        logic [31:0] ctrl;
        cycles = 0;
        ok     = 1'b0;
        while (cycles <= limit) begin
            bus_read(3'd2, ctrl);
            if (ctrl[2]) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    function automatic logic [31:0] model_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic run_gcd(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int max_lat);
        logic [31:0] rd;
        int          cyc;
        logic        ok;
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, a);
        bus_write(3'd1, b);
        bus_write(3'd2, 32'h1);
        wait_done(100, cyc, ok);
        check({name, " done_seen"}, 32'(ok), 32'd1);
        check({name, " latency_ok"}, 32'(cyc <= max_lat), 32'd1);
        bus_read(3'd3, rd);
        check({name, " result"}, rd, exp);
        bus_read(3'd2, rd);
        check({name, " ctrl"}, rd, 32'h4);
    endtask

    initial begin
        logic [31:0] rd, ra, rb;
        int          cyc;
        logic        ok;

        vecs[0] = '{32'd8,        32'd6,        32'd2,      8};
        vecs[1] = '{32'd128,      32'd12,       32'd4,      8};
        vecs[2] = '{32'd65536,    32'd4000,     32'd32,     8};
        vecs[3] = '{32'd0,        32'd9,        32'd9,      0};
        vecs[4] = '{32'd7,        32'd0,        32'd7,      0};
        vecs[5] = '{32'd0,        32'd0,        32'd0,      0};
        vecs[6] = '{32'h7FFFFFFF, 32'h7FFFFFFE, 32'd1,      66};
        vecs[7] = '{32'h80000000, 32'h00010000, 32'd65536,  66};

        bus.chipselect = 1'b0;
        bus.address    = '0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.read       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("reset reg%0d", i), rd, 32'd0);
        end

        // gcd(8,6) walkthrough with readback and again
        bus_write(3'd0, 32'd8);
        bus_write(3'd1, 32'd6);
        bus_read(3'd0, rd);
        check("readback A", rd, 32'd8);
        bus_read(3'd1, rd);
        check("readback B", rd, 32'd6);
        bus_write(3'd2, 32'h1);
        repeat (20) @(posedge clk);
        #1;
        bus_read(3'd2, rd);
        check("gcd86 ctrl done", rd, 32'h4);
        bus_read(3'd3, rd);
        check("gcd86 result", rd, 32'd2);
        bus_write(3'd2, 32'h2);
        bus_read(3'd2, rd);
        check("again clears done", rd, 32'h0);
        bus_read(3'd3, rd);
        check("result retained", rd, 32'd2);

        // Result is read-only, upper addresses read 0, idle bus reads 0
        bus_write(3'd3, 32'hDEADBEEF);
        bus_read(3'd3, rd);
        check("result write ignored", rd, 32'd2);
        bus_write(3'd5, 32'h12345678);
        bus_read(3'd5, rd);
        check("addr5 reads 0", rd, 32'd0);
        bus.address = 3'd3;
        bus.read    = 1'b1;
        #1;
        check("no chipselect reads 0", bus.readdata, 32'd0);
        bus.read = 1'b0;

        for (int i = 0; i < 8; i++)
            run_gcd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].max_lat);

        // go and again in one word: go wins
        bus_write(3'd0, 32'd12);
        bus_write(3'd1, 32'd18);
        bus_write(3'd2, 32'h3);
        bus_read(3'd2, rd);
        check("go+again busy", rd, 32'h8);
        wait_done(100, cyc, ok);
        bus_read(3'd3, rd);
        check("go+again result", rd, 32'd6);

        // Busy protection
        bus_write(3'd2, 32'h2);
        bus_write(3'd0, 32'hFFFFFFFF);
        bus_write(3'd1, 32'd1);
        bus_write(3'd2, 32'h1);
        bus_read(3'd2, rd);
        check("busy flag", rd, 32'h8);
        bus_write(3'd0, 32'd5);
        bus_write(3'd2, 32'h1);
        bus_read(3'd0, rd);
        check("A protected", rd, 32'hFFFFFFFF);
        wait_done(100, cyc, ok);
        check("busy run done", 32'(ok), 32'd1);
        check("busy run latency", 32'(cyc <= 66), 32'd1);
        bus_read(3'd3, rd);
        check("busy run result", rd, 32'd1);

        // Reset mid-run
        bus_write(3'd2, 32'h1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #2;
        bus_read(3'd2, rd);
        check("reset async ctrl", rd, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("midrun reset reg%0d", i), rd, 32'd0);
        end

        // Random operands against Euclid reference
        for (int i = 0; i < 24; i++) begin
            ra = 32'($urandom_range(0, 65535)) << $urandom_range(0, 15);
            rb = 32'($urandom_range(0, 65535)) << $urandom_range(0, 15);
            if (i % 5 == 0) begin
                ra = $urandom;
                rb = $urandom;
            end
            if (i == 7) ra = 32'd0;
            run_gcd($sformatf("rand%0d", i), ra, rb, model_gcd(ra, rb),
                    (ra == 0 || rb == 0) ? 0 : 66);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
